cra_next: RTL

CRA_NEXT -- requirements
Module: cra_next

---
 rtl/cra_next.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cra_next.sv
// Microcode next-address sequencer: computes the next control-RAM address
// from force/return/dispatch/skip/jump sources and keeps a subroutine return stack.
module cra_next #(
  parameter int         ADR_W    = 12,
  parameter int         DEPTH    = 16,
  parameter logic [5:0] RET_CODE = 6'h01
) (
  input  logic                   eboxClk,
  input  logic                   eboxReset_n,
  input  logic                   eboxHold,
  input  logic                   forceLd,
  input  logic [ADR_W-1:0]       forceAdr,
  input  logic [ADR_W-1:0]       CRAM_J,
  input  logic                   CRAM_CALL,
  input  logic [5:0]             CRAM_DISP,
  input  logic                   skipTrue,
  input  logic                   dispEn,
  input  logic [ADR_W-1:0]       dispOr,
  output logic [ADR_W-1:0]       CRADR,
  output logic [$clog2(DEPTH):0] stackDepth,
  output logic                   stackOvf,
  output logic                   stackUnf
);

  localparam int IW = $clog2(DEPTH);
  localparam int DW = IW + 1;

  logic [ADR_W-1:0] stack_mem [DEPTH];

  logic             is_ret;
  logic             empty;
  logic             full;
  logic [IW-1:0]    top_idx;
  logic [ADR_W-1:0] top_adr;
  logic [ADR_W-1:0] next_adr;
  logic [DW-1:0]    depth_nxt;
  logic             wr_en;
  logic [IW-1:0]    wr_idx;
  logic             set_ovf;
  logic             set_unf;

  assign is_ret  = (CRAM_DISP == RET_CODE);
  assign empty   = (stackDepth == '0);
  assign full    = (stackDepth == DW'(DEPTH));
  assign top_idx = IW'(stackDepth - DW'(1));
  assign top_adr = stack_mem[top_idx];

  // Address selection; every combination is a bitwise OR, never an add.
  always_comb begin
    if (forceLd) begin
      next_adr = forceAdr;
    end else if (is_ret) begin
      next_adr = empty ? CRAM_J : (top_adr | CRAM_J);
    end else if (dispEn) begin
      next_adr = CRAM_J | dispOr;
    end else begin
      next_adr = CRAM_J | {{(ADR_W-1){1'b0}}, skipTrue};
    end
  end

  // Stack bookkeeping. A simultaneous call+return overwrites the top entry
  // in place, after the return address has already been read from it.
  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    depth_nxt = stackDepth;
    wr_en     = 1'b0;
    wr_idx    = IW'(stackDepth);
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    if (forceLd) begin
      depth_nxt = '0;
    end else if (CRAM_CALL && is_ret) begin
      wr_en = 1'b1;
      if (empty) begin
        wr_idx    = '0;
        depth_nxt = DW'(1);
        set_unf   = 1'b1;
      end else begin
        wr_idx = top_idx;
      end
    end else if (CRAM_CALL) begin
      if (full) begin
        set_ovf = 1'b1;
      end else begin
        wr_en     = 1'b1;
        depth_nxt = stackDepth + DW'(1);
      end
    end else if (is_ret) begin
      if (empty) begin
        set_unf = 1'b1;
      end else begin
        depth_nxt = stackDepth - DW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the same pre-edge values.
  always_ff @(posedge eboxClk or negedge eboxReset_n) begin
    if (!eboxReset_n) begin
      CRADR      <= '0;
      stackDepth <= '0;
      stackOvf   <= 1'b0;
      stackUnf   <= 1'b0;
    end else if (!eboxHold) begin
      CRADR      <= next_adr;
      stackDepth <= depth_nxt;
      stackOvf   <= stackOvf | set_ovf;
      stackUnf   <= stackUnf | set_unf;
    end
  end

  // NOTE: the stack array is not reset; entries at or above the depth are
  // never read as valid data, so clearing them would only cost logic.
  always_ff @(posedge eboxClk) begin
    if (!eboxHold && wr_en) begin
      stack_mem[wr_idx] <= CRADR;
    end
  end

endmodule
